mac_seq_ctrl: RTL
=================

Name: mac_seq_ctrl

Overview:
- Sequencing controller for a single signed MAC unit: 17-bit activation × 8-bit weight, added to a 32-bit accumulator input, registered output, with ce and sclr.
- Computes one output-pixel dot product over a variable number of input channels × taps per channel, seeded with a bias.
- Drives the read addresses of the activation and weight buffers (synchronous RAM, 1-cycle read latency) and the MAC control and accumulator inputs.
- Returns the 32-bit result on a valid/ready handshake.

Parameters:
ADDR_W, 10, width of activation/weight buffer addresses
CH_W, 8, width of channel count (1..2^CH_W-1 channels)
TAP_W, 4, width of taps-per-channel count (e.g. 9 for 3x3)

Ports:
clk  in  1  clock, rising edge
sclr_n  in  1  asynchronous active-low reset
start  in  1  one-cycle request; sampled only in IDLE
cfg_num_ch  in  CH_W  number of input channels
cfg_taps  in  TAP_W  taps per channel
cfg_act_base  in  ADDR_W  activation start address
cfg_act_stride  in  ADDR_W  activation address step between channels
cfg_wgt_base  in  ADDR_W  weight start address
cfg_bias  in  32  signed bias, seeds accumulator
stall  in  1  suppresses read issue in RUN
busy  out  1  high in any state except IDLE
rd_en  out  1  buffer read enable
act_addr  out  ADDR_W  activation read address
wgt_addr  out  ADDR_W  weight read address
mac_ce  out  1  MAC clock enable
mac_sclr  out  1  MAC clear
mac_c  out  32  signed MAC accumulator input
mac_p  in  32  signed MAC output
out_result  out  32  signed final sum
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result

Behaviour:
- Reset (sclr_n low, asynchronous): state IDLE.
  - All outputs 0: busy, rd_en, act_addr, wgt_addr, mac_ce, mac_sclr, mac_c, out_result, out_valid.
  - Internal counters and pipeline flags cleared.
  - Reset mid-operation discards all in-flight work; no partial result is produced.
- All cfg_* inputs are latched when start is accepted. Later changes have no effect until the next accept.
- IDLE:
  - start=1 with N = cfg_num_ch*cfg_taps ≠ 0 -> CLR.
  - start=1 with N = 0 -> DONE, out_result = cfg_bias.
  - start=0 -> stay in IDLE.
- CLR (1 cycle): mac_sclr=1; tap counter=0; channel counter=0; act pointer=cfg_act_base; channel-start register=cfg_act_base; wgt pointer=cfg_wgt_base -> RUN.
- RUN:
  - Each cycle with stall=0: rd_en=1 with current act_addr/wgt_addr, then advance.
    - wgt_addr +1 always.
    - act_addr +1 within a channel.
    - On the last tap of a channel: channel-start += cfg_act_stride, and act_addr = new channel-start.
  - stall=1: rd_en=0, pointers and counters hold.
  - After the issue of read N -> DRAIN.
- Datapath pipeline:
  - mac_ce = rd_en delayed 1 cycle, aligned with RAM data.
  - A "first" flag travels with read #1. mac_c = latched bias when the delayed first flag is set, otherwise mac_c = mac_p (feedback).
  - Stall bubbles give mac_ce=0; the MAC holds and the feedback stays correct.
- DRAIN (2 cycles, stall ignored): last mac_ce occurs in the first DRAIN cycle. At the end of the second cycle, out_result <= mac_p -> DONE.
- DONE:
  - out_valid=1; out_result held stable.
  - out_valid && out_ready -> IDLE, out_valid=0 the next cycle.
  - start ignored in every non-IDLE state, including DONE.
- Latency without stalls: start accepted at edge 0 -> out_valid high in cycle N+4. Each stall cycle in RUN adds 1.
- Arithmetic:
  - Address pointers wrap modulo 2^ADDR_W with no error.
  - N is computed at CH_W+TAP_W bits, no truncation.
  - The accumulator is 32-bit two's complement; overflow wraps (behaviour of the MAC itself).
- rd_en, mac_ce and mac_sclr are never high simultaneously with out_valid.

Test Plan:
- 1 ch, 3 taps, act_base=0x10, wgt_base=0x20, bias=5, acts {2,-3,4}, wgts {1,2,-1} -> addresses 0x10..0x12 / 0x20..0x22, out_result=5+2-6-4=-3, out_valid in cycle 7.
- 3 ch, 2 taps, act_base=0, stride=0x40, wgt_base=0x100 -> act_addr sequence 0,1,0x40,0x41,0x80,0x81; wgt_addr 0x100..0x105; result matches reference sum; done at cycle 10.
- Same as first case with stall high for 2 cycles mid-RUN -> rd_en/mac_ce gaps of 2, identical result, out_valid in cycle 9.
- cfg_num_ch=0, bias=-7 -> no rd_en or mac_ce ever, out_result=-7, out_valid the cycle after start.
- out_ready held low 5 cycles, start pulsed during DONE -> out_result stable, start ignored; after handshake IDLE, then a new start proceeds normally.
- act_base=2^ADDR_W-2 with 4 taps -> act_addr wraps 0x3FE,0x3FF,0,1. Separately, sclr_n pulsed low mid-RUN -> all outputs 0 immediately, state IDLE, no out_valid.

Source files
------------

// File: rtl/mac_seq_ctrl_if.sv
// Signal bundle between mac_seq_ctrl and its surroundings: job request/config,
// buffer read port, MAC control/feedback and the result handshake.
interface mac_seq_ctrl_if #(
  parameter int ADDR_W = 10,
  parameter int CH_W   = 8,
  parameter int TAP_W  = 4
);
  logic                start;
  logic [CH_W-1:0]     cfg_num_ch;
  logic [TAP_W-1:0]    cfg_taps;
  logic [ADDR_W-1:0]   cfg_act_base;
  logic [ADDR_W-1:0]   cfg_act_stride;
  logic [ADDR_W-1:0]   cfg_wgt_base;
  logic signed [31:0]  cfg_bias;
  logic                stall;
  logic                busy;
  logic                rd_en;
  logic [ADDR_W-1:0]   act_addr;
  logic [ADDR_W-1:0]   wgt_addr;
  logic                mac_ce;
  logic                mac_sclr;
  logic signed [31:0]  mac_c;
  logic signed [31:0]  mac_p;
  logic signed [31:0]  out_result;
  logic                out_valid;
  logic                out_ready;

  modport master (
    input  start, cfg_num_ch, cfg_taps, cfg_act_base, cfg_act_stride,
           cfg_wgt_base, cfg_bias, stall, mac_p, out_ready,
    output busy, rd_en, act_addr, wgt_addr, mac_ce, mac_sclr, mac_c,
           out_result, out_valid
  );

  modport slave (
    output start, cfg_num_ch, cfg_taps, cfg_act_base, cfg_act_stride,
           cfg_wgt_base, cfg_bias, stall, mac_p, out_ready,
    input  busy, rd_en, act_addr, wgt_addr, mac_ce, mac_sclr, mac_c,
           out_result, out_valid
  );
endinterface

// File: rtl/mac_seq_ctrl.sv
// Sequencer for one signed MAC: walks channels x taps through the activation and
// weight buffers, seeds the accumulator with a bias and returns the dot product.
module mac_seq_ctrl #(
  parameter int ADDR_W = 10,
  parameter int CH_W   = 8,
  parameter int TAP_W  = 4
) (
  input  logic           clk,
  input  logic           sclr_n,
  mac_seq_ctrl_if.master bus
);

  localparam int N_W = CH_W + TAP_W;
  localparam logic [TAP_W-1:0]  TAP_ONE  = {{(TAP_W-1){1'b0}}, 1'b1};
  localparam logic [N_W-1:0]    N_ONE    = {{(N_W-1){1'b0}}, 1'b1};
  localparam logic [ADDR_W-1:0] ADDR_ONE = {{(ADDR_W-1){1'b0}}, 1'b1};

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_CLR    = 3'd1,
    ST_RUN    = 3'd2,
    ST_DRAIN1 = 3'd3,
    ST_DRAIN2 = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  state_t              state_r;
  logic [N_W-1:0]      n_r;
  logic [N_W-1:0]      rem_r;
  logic [TAP_W-1:0]    taps_r;
  logic [TAP_W-1:0]    tap_cnt_r;
  logic [ADDR_W-1:0]   act_base_r;
  logic [ADDR_W-1:0]   stride_r;
  logic [ADDR_W-1:0]   wgt_base_r;
  logic [ADDR_W-1:0]   act_ptr_r;
  logic [ADDR_W-1:0]   ch_start_r;
  logic [ADDR_W-1:0]   wgt_ptr_r;
  logic signed [31:0]  bias_r;
  logic signed [31:0]  out_result_r;
  logic                first_pend_r;
  logic                first_d_r;
  logic                mac_ce_r;
  logic                mac_sclr_r;
  logic                busy_r;
  logic                out_valid_r;

  logic [N_W-1:0]      n_s;
  logic                rd_en_s;
  logic                last_tap_s;
  logic [ADDR_W-1:0]   next_ch_start_s;
  logic signed [31:0]  mac_c_s;

  // Job size at full width, read issue gating and channel-boundary detection
  always_comb begin
    n_s             = {{TAP_W{1'b0}}, bus.cfg_num_ch} * {{CH_W{1'b0}}, bus.cfg_taps};
    last_tap_s      = (tap_cnt_r == (taps_r - TAP_ONE));
    next_ch_start_s = ch_start_r + stride_r;
    if (state_r == ST_RUN) begin
      rd_en_s = ~bus.stall;
    end else begin
      rd_en_s = 1'b0;
    end
  end

  // Accumulator input: bias for the first product, otherwise the MAC's own output
  always_comb begin
    mac_c_s = 32'sd0;
    if (mac_ce_r) begin
      if (first_d_r) begin
        mac_c_s = bias_r;
      end else begin
        mac_c_s = bus.mac_p;
      end
    end else begin
      mac_c_s = 32'sd0;
    end
  end

  // Sequencer state, address walk, read-to-MAC alignment and result handshake
  always_ff @(posedge clk or negedge sclr_n) begin
    if (!sclr_n) begin
      state_r      <= ST_IDLE;
      n_r          <= {N_W{1'b0}};
      rem_r        <= {N_W{1'b0}};
      taps_r       <= {TAP_W{1'b0}};
      tap_cnt_r    <= {TAP_W{1'b0}};
      act_base_r   <= {ADDR_W{1'b0}};
      stride_r     <= {ADDR_W{1'b0}};
      wgt_base_r   <= {ADDR_W{1'b0}};
      act_ptr_r    <= {ADDR_W{1'b0}};
      ch_start_r   <= {ADDR_W{1'b0}};
      wgt_ptr_r    <= {ADDR_W{1'b0}};
      bias_r       <= 32'sd0;
      out_result_r <= 32'sd0;
      first_pend_r <= 1'b0;
      first_d_r    <= 1'b0;
      mac_ce_r     <= 1'b0;
      mac_sclr_r   <= 1'b0;
      busy_r       <= 1'b0;
      out_valid_r  <= 1'b0;
    end else begin
      // RAM data arrives one cycle after the read, so the MAC enable trails rd_en
      mac_ce_r  <= rd_en_s;
      first_d_r <= rd_en_s & first_pend_r;
      case (state_r)
        ST_IDLE: begin
          mac_sclr_r <= 1'b0;
          if (bus.start) begin
            n_r        <= n_s;
            taps_r     <= bus.cfg_taps;
            act_base_r <= bus.cfg_act_base;
            stride_r   <= bus.cfg_act_stride;
            wgt_base_r <= bus.cfg_wgt_base;
            bias_r     <= bus.cfg_bias;
            busy_r     <= 1'b1;
            if (n_s != {N_W{1'b0}}) begin
              mac_sclr_r <= 1'b1;
              state_r    <= ST_CLR;
            end else begin
              out_result_r <= bus.cfg_bias;
              out_valid_r  <= 1'b1;
              state_r      <= ST_DONE;
            end
          end else begin
            busy_r  <= 1'b0;
            state_r <= ST_IDLE;
          end
        end
        ST_CLR: begin
          mac_sclr_r   <= 1'b0;
          tap_cnt_r    <= {TAP_W{1'b0}};
          rem_r        <= n_r;
          act_ptr_r    <= act_base_r;
          ch_start_r   <= act_base_r;
          wgt_ptr_r    <= wgt_base_r;
          first_pend_r <= 1'b1;
          state_r      <= ST_RUN;
        end
        ST_RUN: begin
          if (rd_en_s) begin
            first_pend_r <= 1'b0;
            wgt_ptr_r    <= wgt_ptr_r + ADDR_ONE;
            rem_r        <= rem_r - N_ONE;
            if (last_tap_s) begin
              tap_cnt_r  <= {TAP_W{1'b0}};
              ch_start_r <= next_ch_start_s;
              act_ptr_r  <= next_ch_start_s;
            end else begin
              tap_cnt_r  <= tap_cnt_r + TAP_ONE;
              act_ptr_r  <= act_ptr_r + ADDR_ONE;
            end
            if (rem_r == N_ONE) begin
              state_r <= ST_DRAIN1;
            end else begin
              state_r <= ST_RUN;
            end
          end else begin
            state_r <= ST_RUN;
          end
        end
        ST_DRAIN1: begin
          state_r <= ST_DRAIN2;
        end
        ST_DRAIN2: begin
          out_result_r <= bus.mac_p;
          out_valid_r  <= 1'b1;
          state_r      <= ST_DONE;
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
            busy_r      <= 1'b0;
            state_r     <= ST_IDLE;
          end else begin
            state_r <= ST_DONE;
          end
        end
        default: begin
          state_r      <= ST_IDLE;
          busy_r       <= 1'b0;
          out_valid_r  <= 1'b0;
          mac_sclr_r   <= 1'b0;
          first_pend_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.busy       = busy_r;
  assign bus.rd_en      = rd_en_s;
  assign bus.act_addr   = act_ptr_r;
  assign bus.wgt_addr   = wgt_ptr_r;
  assign bus.mac_ce     = mac_ce_r;
  assign bus.mac_sclr   = mac_sclr_r;
  assign bus.mac_c      = mac_c_s;
  assign bus.out_result = out_result_r;
  assign bus.out_valid  = out_valid_r;

endmodule
